pdm_capture: RTL



---
 rtl/pdm_capture_if.sv | 26 ++
 rtl/pdm_capture.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pdm_capture_if.sv
// PCM capture bundle: sample-rate strobe and pad bit in, recovered sample and status pulses out.
interface pdm_capture_if #(
    parameter int BITDEPTH = 14
);
    logic                sample_clock;
    logic                pdm_in;
    logic [BITDEPTH-1:0] pcm;
    logic                pcm_valid;
    logic                window_err;

    modport master (
        output sample_clock,
        output pdm_in,
        input  pcm,
        input  pcm_valid,
        input  window_err
    );

    modport slave (
        input  sample_clock,
        input  pdm_in,
        output pcm,
        output pcm_valid,
        output window_err
    );
endinterface

// File: rtl/pdm_capture.sv
// Recovers unsigned PCM from a 1-bit pulse-density stream with an order-2 CIC decimator
// (integrators at clk, combs at each sample_clock rising edge).
module pdm_capture #(
    parameter int BITDEPTH    = 14,
    parameter int WINDOW_LOG2 = 8
) (
    input  logic          clk,
    input  logic          rst,
    pdm_capture_if.slave  bus
);
    localparam int IW    = 2 * WINDOW_LOG2 + 1;
    localparam int CW    = WINDOW_LOG2 + 1;
    localparam int SHIFT = 2 * WINDOW_LOG2 - BITDEPTH;

    localparam logic [CW-1:0] WIN_R   = CW'(1) << WINDOW_LOG2;
    localparam logic [IW-1:0] PCM_MAX = IW'((1 << BITDEPTH) - 1);

    typedef enum logic [1:0] {
        ST_FIRST,
        ST_PRIME0,
        ST_PRIME1,
        ST_RUN
    } state_t;

    state_t state_q, state_d;

    logic [1:0]          sync_q;
    logic                sc_q;
    logic [CW-1:0]       wcnt_q, wcnt_d;
    logic [IW-1:0]       i1_q, i2_q;
    logic [IW-1:0]       xd_q, c1d_q;
    logic [IW-1:0]       c1, c2, y;
    logic [BITDEPTH-1:0] pcm_q, pcm_d, scaled;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                edge_det;
    logic                win_ok;

    assign edge_det = bus.sample_clock & ~sc_q;
    // A saturated counter can never equal R, so edge+saturation falls out as an error.
    assign win_ok   = (wcnt_q == WIN_R);

    assign c1     = i2_q - xd_q;
    assign c2     = c1 - c1d_q;
    assign y      = c2 >> SHIFT;
    assign scaled = (y > PCM_MAX) ? '1 : y[BITDEPTH-1:0];

    always_comb begin
        wcnt_d = wcnt_q;
        if (edge_det) begin
            wcnt_d = CW'(1);
        end else if (wcnt_q != '1) begin
            wcnt_d = wcnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            sc_q    <= 1'b0;
            wcnt_q  <= '0;
            i1_q    <= '0;
            i2_q    <= '0;
            xd_q    <= '0;
            c1d_q   <= '0;
            pcm_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], bus.pdm_in};
            sc_q    <= bus.sample_clock;
            wcnt_q  <= wcnt_d;
            i1_q    <= i1_q + {{(IW-1){1'b0}}, sync_q[1]};
            i2_q    <= i2_q + i1_q;
            if (edge_det) begin
                xd_q  <= i2_q;
                c1d_q <= c1;
            end
            pcm_q   <= pcm_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (edge_det) begin
            if (state_q == ST_FIRST || !win_ok) begin
                state_d = ST_PRIME0;
            end else begin
                case (state_q)
                    ST_PRIME0: state_d = ST_PRIME1;
                    ST_PRIME1: state_d = ST_RUN;
                    default:   state_d = ST_RUN;
                endcase
            end
        end
    end

    always_comb begin
        pcm_d   = pcm_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        if (edge_det && state_q != ST_FIRST) begin
            if (!win_ok) begin
                err_d = 1'b1;
            end else if (state_q == ST_RUN) begin
                valid_d = 1'b1;
                pcm_d   = scaled;
            end
        end
    end

    assign bus.pcm        = pcm_q;
    assign bus.pcm_valid  = valid_q;
    assign bus.window_err = err_q;
endmodule
